// File: rtl/tohost_wr_arb.sv
// tohost_wr_arb
// Round-robin arbiter that lets NREQ DSP-side producers share the single
// write port of the to-host BRAM. The BRAM is split into NREQ equal
// segments. Each requester fills its own segment sequentially, and a
// segment stops accepting data once it holds SEGDEPTH words. The host drains
// the segments and releases all of them with a one-cycle clear pulse.
//
// Ports
//   dspclk     : clock, all logic on the rising edge
//   dspreset   : asynchronous active-high reset
//   req_valid  : per-requester data valid
//   req_data   : per-requester data, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   req_ready  : per-requester accept (combinational)
//   clear      : one-cycle pulse that empties every segment
//   bram_we    : registered BRAM write enable
//   bram_addr  : registered BRAM write address {req_id, ptr}
//   bram_data  : registered BRAM write data
//   full       : registered per-segment full flags
//   wcount     : registered per-segment word counts, 0..SEGDEPTH
module tohost_wr_arb #(
   parameter int NREQ      = 4,
   parameter int ADDRWIDTH = 13,
   parameter int DATAWIDTH = 64
) (
   input  logic                                       dspclk,
   input  logic                                       dspreset,
   input  logic [NREQ-1:0]                            req_valid,
   input  logic [NREQ*DATAWIDTH-1:0]                  req_data,
   output logic [NREQ-1:0]                            req_ready,
   input  logic                                       clear,
   output logic                                       bram_we,
   output logic [ADDRWIDTH-1:0]                       bram_addr,
   output logic [DATAWIDTH-1:0]                       bram_data,
   output logic [NREQ-1:0]                            full,
   output logic [NREQ*(ADDRWIDTH-$clog2(NREQ)+1)-1:0] wcount
);

   localparam int IDW   = $clog2(NREQ);
   localparam int SEGAW = ADDRWIDTH - IDW;
   localparam int CW    = SEGAW + 1;
   localparam logic [CW-1:0]  LAST_SLOT  = CW'((1 << SEGAW) - 1);
   localparam logic [IDW-1:0] LAST_INDEX = IDW'(NREQ - 1);

   logic [DATAWIDTH-1:0] data_arr   [NREQ];
   logic [CW-1:0]        wcount_reg [NREQ];
   logic                 full_reg   [NREQ];
   logic [NREQ-1:0]      eligible;
   logic [IDW-1:0]       last_grant_reg;
   logic [IDW-1:0]       search_idx;
   logic [IDW-1:0]       grant_id;
   logic                 grant_found;
   logic [NREQ-1:0]      grant_onehot;
   logic                 handshake;

   // Per-segment state. The write pointer is the low SEGAW bits of the word
   // count: both reset and clear together and step together, and the count's
   // low bits wrap to 0 exactly when the count reaches SEGDEPTH.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_seg
      assign data_arr[gi]             = req_data[gi*DATAWIDTH +: DATAWIDTH];
      assign wcount[gi*CW +: CW]      = wcount_reg[gi];
      assign full[gi]                 = full_reg[gi];
      assign eligible[gi]             = req_valid[gi] & ~full_reg[gi];

      always_ff @(posedge dspclk or posedge dspreset) begin
         if (dspreset) begin
            wcount_reg[gi] <= '0;
            full_reg[gi]   <= 1'b0;
         end else if (clear) begin
            wcount_reg[gi] <= '0;
            full_reg[gi]   <= 1'b0;
         end else if (req_ready[gi]) begin
            wcount_reg[gi] <= wcount_reg[gi] + 1'b1;
            if (wcount_reg[gi] == LAST_SLOT) begin
               full_reg[gi] <= 1'b1;
            end
         end
      end
   end

   // Rotating priority search starting just after the last winner. NREQ is a
   // power of two, so the IDW-bit index sum wraps modulo NREQ on its own; the
   // final step (k == NREQ) revisits the last winner itself.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      search_idx  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         search_idx = last_grant_reg + IDW'(k);
         if (!grant_found && eligible[search_idx]) begin
            grant_found = 1'b1;
            grant_id    = search_idx;
         end
      end
   end

   always_comb begin
      grant_onehot = '0;
      if (grant_found) begin
         grant_onehot = NREQ'(1) << grant_id;
      end
      // clear wins over any valid; nothing is accepted while reset is held.
      req_ready = grant_onehot & {NREQ{~clear & ~dspreset}};
      handshake = |req_ready;
   end

   // Write port registers. Address and data only move on an accepted word so
   // the last write stays visible on the port while bram_we is low.
   always_ff @(posedge dspclk or posedge dspreset) begin
      if (dspreset) begin
         bram_we        <= 1'b0;
         bram_addr      <= '0;
         bram_data      <= '0;
         last_grant_reg <= LAST_INDEX;
      end else begin
         bram_we <= handshake;
         if (handshake) begin
            bram_addr      <= {grant_id, wcount_reg[grant_id][SEGAW-1:0]};
            bram_data      <= data_arr[grant_id];
            last_grant_reg <= grant_id;
         end
         if (clear) begin
            last_grant_reg <= LAST_INDEX;
         end
      end
   end

endmodule

// File: doc/tohost_wr_arb.md
Name: tohost_wr_arb

Overview:
- Round-robin write arbiter that shares one BRAM-to-host write port between NREQ DSP-side producers (per-channel readout/accumulator streams) in the dspclk domain.
- The BRAM is statically split into NREQ equal segments. Each requester writes sequentially into its own segment through a private write pointer.
- A segment stops accepting data when it is full. The host drains the segments and releases them with a clear pulse.
- Sits between the DSP result producers and the bram_tohost write side; the host reads the BRAM through the existing host port.

Parameters:
- NREQ, 4, number of requesters; power of two, 2..16.
- ADDRWIDTH, 13, BRAM word-address width.
- DATAWIDTH, 64, BRAM word width.
- SEGAW, ADDRWIDTH-$clog2(NREQ), derived (localparam); per-segment address width. SEGDEPTH = 2**SEGAW words.

Ports:
- dspclk  in  1  clock; all logic on the rising edge.
- dspreset  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*DATAWIDTH  per-requester data; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- req_ready  out  NREQ  per-requester accept; combinational.
- clear  in  1  single-cycle pulse: empties all segments.
- bram_we  out  1  registered write enable.
- bram_addr  out  ADDRWIDTH  registered write address = {req_id, ptr}.
- bram_data  out  DATAWIDTH  registered write data.
- full  out  NREQ  registered; segment i holds SEGDEPTH words.
- wcount  out  NREQ*(SEGAW+1)  registered words written per segment, range 0..SEGDEPTH.

Behaviour:
- Reset (async assert, sync release, no clock required while asserted): bram_we=0, bram_addr=0, bram_data=0, all pointers/wcount=0, full=0, last_grant=NREQ-1. req_ready=0 while reset is asserted.
- Eligibility: eligible[i] = req_valid[i] & ~full[i].
- Arbitration:
  - Search starts at (last_grant+1) mod NREQ and wraps; the first eligible index wins.
  - At most one grant per cycle.
  - req_ready[i] = (grant==i) & eligible[i] & ~clear.
  - req_ready may depend on req_valid. req_valid must not depend on req_ready.
- Handshake: req_valid[i] & req_ready[i] at edge N causes the following at edge N:
  - bram_we<=1, bram_addr<={i[log2 NREQ-1:0], ptr[i]}, bram_data<=req_data[i].
  - ptr[i]<=ptr[i]+1 (wraps to 0 at SEGDEPTH).
  - wcount[i]<=wcount[i]+1.
  - last_grant<=i.
  - The write is visible on the BRAM port in the cycle after acceptance (latency 1).
- No handshake in a cycle: bram_we<=0; bram_addr and bram_data hold their previous values.
- Full:
  - full[i]<=1 on the edge where wcount[i] goes SEGDEPTH-1 -> SEGDEPTH.
  - While full[i]=1, req_ready[i]=0 and requester i is skipped; its data is held back, never dropped.
  - Other requesters are unaffected.
- Throughput: one word per cycle aggregate. With k continuously valid, non-full requesters, each receives exactly one grant every k cycles.
- clear:
  - Forces req_ready=0 in that cycle, so no handshake and bram_we<=0.
  - On that edge: all ptr, wcount and full <=0; last_grant<=NREQ-1.
  - clear wins over a simultaneous valid; the requester retries next cycle.
- Requester deasserting valid without a handshake is legal and costs nothing. The pointer only advances on a handshake.
- Reset mid-transfer: an in-flight registered write is discarded (bram_we=0 immediately). Segment contents are not erased.

Test Plan:
- NREQ=4, SEGAW=11. req_valid=4'b1111 held from reset release, data = {i, seq} -> grant order 0,1,2,3,0,... A 12-cycle window shows bram_addr 0x000, 0x800, 0x1000, 0x1800, 0x001, ... with bram_we=1 every cycle; each wcount=3.
- Only req 2 valid for 5 cycles -> five consecutive writes at 0x1000..0x1004, one per cycle. wcount[2]=5; other wcounts=0.
- Req 1 streams 2048 words -> full[1]=1 after the 2048th accept, and the last address written is 0x0FFF. Thereafter req_ready[1]=0 while req 0 is still accepted at its next pointer.
- clear pulsed in the same cycle that req 0 and req 3 are valid -> req_ready=0 and no write that cycle. Next cycle req 0 writes at 0x000 and wcount is all zeros before it.
- dspreset asserted asynchronously mid-stream (between clock edges) -> bram_we=0 and full=0 at once, without a clock edge. After release, the first grant goes to req 0 at address 0x000.
- Req 0 toggles valid every cycle while req 1 is held valid -> req 1 is never starved (at least one grant per 2 cycles). Req 0 is granted only in cycles where it is valid.
